// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage that sits directly after the branch unit. It holds
// the architectural PC and drives the instruction-memory port with at most
// one request outstanding. Fetched words go to decode through a one-entry
// valid/ready buffer. A redirect from execute replaces the PC and flushes
// the buffer. If a request is still in flight when the redirect arrives,
// its response is squashed.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned PC does not fetch. Instead it produces a single
//               fault entry (NOP word, out_fault=1). The unit then idles
//               until the next redirect.
//   undefined : redirect targets are forced word-aligned and out_fault is
//               tied to 0.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   redirect        taken change of flow (single-cycle pulse)
//   redirect_pc     redirect target, sampled while redirect=1
//   imem_req        memory request valid
//   imem_addr       memory request address
//   imem_ready      memory accepts request (imem_req && imem_ready)
//   imem_rvalid     response valid, one per accepted request
//   imem_rdata      response instruction word
//   out_valid       output buffer holds an instruction
//   out_ready       decode accepts the buffered instruction
//   out_instr       buffered instruction word
//   out_pc          address of out_instr
//   out_fault       misaligned-fetch fault marker
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  localparam logic [1:0]  S_REQ   = 2'd0;
  localparam logic [1:0]  S_WAIT  = 2'd1;
  localparam logic [1:0]  S_FAULT = 2'd2;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  state_q, state_d;
  logic        kill_q, kill_d;
  logic        outValid_q, outValid_d;
  logic [31:0] outInstr_q, outInstr_d;
  logic [31:0] outPc_q, outPc_d;
  logic        bufFree;
  logic [31:0] redirectTarget;

  // A new entry may only be issued when the buffer is empty or is being
  // drained this cycle. This is what lets imem_rvalid go without back-pressure.
  assign bufFree = !outValid_q || out_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic outFault_q, outFault_d;
  logic misaligned;

  assign misaligned     = (pc_q[1:0] != 2'b00);
  assign redirectTarget = redirect_pc;
  assign out_fault      = outFault_q;
  assign imem_req       = !rst && (state_q == S_REQ) && bufFree && !redirect
                          && !misaligned;
`else
  assign redirectTarget = redirect_pc & 32'hFFFF_FFFC;
  assign out_fault      = 1'b0;
  assign imem_req       = !rst && (state_q == S_REQ) && bufFree && !redirect;
`endif

  assign imem_addr = pc_q;
  assign out_valid = outValid_q;
  assign out_instr = outInstr_q;
  assign out_pc    = outPc_q;

  // Next-state logic. The normal per-state behaviour is computed first.
  // A redirect then overrides it, because the redirect makes everything
  // fetched so far wrong-path.
  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    kill_d     = kill_q;
    outValid_d = outValid_q;
    outInstr_d = outInstr_q;
    outPc_d    = outPc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    outFault_d = outFault_q;
`endif

    if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misaligned && bufFree && !redirect) begin
          outValid_d = 1'b1;
          outInstr_d = NOP;
          outPc_d    = pc_q;
          outFault_d = 1'b1;
          state_d    = S_FAULT;
        end else
`endif
        if (imem_req && imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          if (kill_q) begin
            kill_d = 1'b0;
          end else begin
            outValid_d = 1'b1;
            outInstr_d = imem_rdata;
            outPc_d    = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
            outFault_d = 1'b0;
`endif
            pc_d       = pc_q + 32'd4;
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // Only a response that is still in flight needs to be killed. If it
    // lands in the same cycle as the redirect, it is dropped right here.
    if (redirect) begin
      pc_d       = redirectTarget;
      outValid_d = 1'b0;
      if ((state_q == S_WAIT) && !imem_rvalid) begin
        kill_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        kill_d  = 1'b0;
        state_d = S_REQ;
      end
    end
  end

  // State registers with asynchronous reset. out_instr resets to a NOP so
  // that decode never sees an undefined word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      state_q    <= S_REQ;
      kill_q     <= 1'b0;
      outValid_q <= 1'b0;
      outInstr_q <= NOP;
      outPc_q    <= RESET_PC;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      kill_q     <= kill_d;
      outValid_q <= outValid_d;
      outInstr_q <= outInstr_d;
      outPc_q    <= outPc_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // The fault marker lives only in the trap build.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outFault_q <= 1'b0;
    end else begin
      outFault_q <= outFault_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed scenarios followed by a randomized phase. A small memory model
// answers every accepted request after a chosen latency. A stream model
// holds the PC that decode should see next: it advances by 4 per transfer
// and jumps to the target on every redirect. Every transfer is compared
// against that model. Fetched words are a function of their address, so a
// word that leaks from the wrong path is caught.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_fault   (out_fault)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          passes;
  int          xferCount;

  // Memory model state.
  bit          pending;
  int          pendCnt;
  logic [31:0] pendAddr;
  int          memLat;
  int          readyPct;
  bit          rdataMode;

  // Stream model state.
  logic [31:0] expPc;
  bit          expIdle;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (rdataMode) return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    return 32'h00A0_0093;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle. Inputs are driven at the falling edge and outputs are
  // sampled shortly after. The memory and stream models are updated from
  // the handshakes that the next rising edge will commit.
  task automatic applyStimulus(input logic rd, input logic [31:0] rdPc,
                               input logic rdy);
    logic [31:0] tgt;
    @(negedge clk);
    redirect    = rd;
    redirect_pc = rdPc;
    out_ready   = rdy;
    imem_ready  = ($urandom_range(99) < readyPct);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pending) begin
      pendCnt--;
      if (pendCnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memWord(pendAddr);
        pending     = 1'b0;
      end
    end
    #1;
    if (out_valid && out_ready && !redirect) begin
      xferCount++;
      if (expIdle) begin
        checkOutput("xferAfterFault", 32'(out_valid), 32'd0);
      end else begin
        checkOutput("xferPc", out_pc, expPc);
        if (TRAP && (expPc[1:0] != 2'b00)) begin
          checkOutput("xferFaultInstr", out_instr, NOP);
          checkOutput("xferFault", 32'(out_fault), 32'd1);
          expIdle = 1'b1;
        end else begin
          checkOutput("xferInstr", out_instr, memWord(expPc));
          checkOutput("xferFault", 32'(out_fault), 32'd0);
          expPc = expPc + 32'd4;
        end
      end
    end
    if (redirect) begin
      tgt     = TRAP ? redirect_pc : (redirect_pc & 32'hFFFF_FFFC);
      expPc   = tgt;
      expIdle = 1'b0;
    end
    if (imem_req && imem_ready) begin
      checkOutput("oneOutstanding", 32'(pending), 32'd0);
      pending  = 1'b1;
      pendCnt  = memLat;
      pendAddr = imem_addr;
    end
  endtask

  task automatic doReset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    pending     = 1'b0;
    pendCnt     = 0;
    expPc       = RESET_PC;
    expIdle     = 1'b0;
    memLat      = 1;
    readyPct    = 100;
    @(negedge clk);
    #1;
    checkOutput("rstReq", 32'(imem_req), 32'd0);
    checkOutput("rstAddr", imem_addr, RESET_PC);
    checkOutput("rstValid", 32'(out_valid), 32'd0);
    checkOutput("rstInstr", out_instr, NOP);
    checkOutput("rstPc", out_pc, RESET_PC);
    checkOutput("rstFault", 32'(out_fault), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    xferCount = 0;
    rdataMode = 1'b0;
    rst       = 1'b1;

    // Streaming with zero-wait memory: one instruction every two cycles.
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s1ReqC1", 32'(imem_req), 32'd1);
    checkOutput("s1AddrC1", imem_addr, 32'h100);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s1ReqC2", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s1ValidC3", 32'(out_valid), 32'd1);
    checkOutput("s1PcC3", out_pc, 32'h100);
    checkOutput("s1InstrC3", out_instr, 32'h00A0_0093);
    checkOutput("s1AddrC3", imem_addr, 32'h104);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s1ValidC4", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s1PcC5", out_pc, 32'h104);
    checkOutput("s1AddrC5", imem_addr, 32'h108);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s1PcC7", out_pc, 32'h108);

    // Decode stalls for five cycles: the buffer holds and no new request goes out.
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("s2HoldValid", 32'(out_valid), 32'd1);
      checkOutput("s2HoldPc", out_pc, 32'h100);
      checkOutput("s2HoldReq", 32'(imem_req), 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s2ResumeReq", 32'(imem_req), 32'd1);
    checkOutput("s2ResumeAddr", imem_addr, 32'h104);

    // Redirect while waiting; the late response is squashed.
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    memLat = 4;
    applyStimulus(1'b0, 32'h0, 1'b1);
    memLat = 1;
    applyStimulus(1'b1, 32'h200, 1'b1);
    checkOutput("s3ReqRedir", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s3AddrKill", imem_addr, 32'h200);
    checkOutput("s3ReqKill", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s3RvalidKilled", 32'(imem_rvalid), 32'd1);
    checkOutput("s3ReqDuringKill", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s3NoLeak", 32'(out_valid), 32'd0);
    checkOutput("s3Req", 32'(imem_req), 32'd1);
    checkOutput("s3Addr", imem_addr, 32'h200);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s3Pc", out_pc, 32'h200);

    // Redirect in the same cycle as the response.
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h300, 1'b1);
    checkOutput("s4Rvalid", 32'(imem_rvalid), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s4Valid", 32'(out_valid), 32'd0);
    checkOutput("s4Req", 32'(imem_req), 32'd1);
    checkOutput("s4Addr", imem_addr, 32'h300);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s4Pc", out_pc, 32'h300);

    // Back-to-back redirects while waiting: the last one wins.
    doReset();
    memLat = 4;
    applyStimulus(1'b0, 32'h0, 1'b1);
    memLat = 1;
    applyStimulus(1'b1, 32'h400, 1'b1);
    applyStimulus(1'b1, 32'h500, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s5Addr", imem_addr, 32'h500);
    checkOutput("s5ReqC4", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s5ReqC5", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s5ReqC6", 32'(imem_req), 32'd1);
    checkOutput("s5AddrC6", imem_addr, 32'h500);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s5Pc", out_pc, 32'h500);

    // Misaligned redirect target.
    doReset();
    applyStimulus(1'b1, 32'h602, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    if (TRAP) begin
      checkOutput("s6TrapReq", 32'(imem_req), 32'd0);
      checkOutput("s6TrapAddr", imem_addr, 32'h602);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("s6Fault", 32'(out_fault), 32'd1);
      checkOutput("s6FaultPc", out_pc, 32'h602);
      checkOutput("s6FaultInstr", out_instr, NOP);
      for (int i = 0; i < 3; i++) begin
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("s6IdleReq", 32'(imem_req), 32'd0);
      end
      applyStimulus(1'b1, 32'h700, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("s6ReqAfter", 32'(imem_req), 32'd1);
      checkOutput("s6AddrAfter", imem_addr, 32'h700);
    end else begin
      checkOutput("s6Req", 32'(imem_req), 32'd1);
      checkOutput("s6Addr", imem_addr, 32'h600);
      applyStimulus(1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("s6Pc", out_pc, 32'h600);
      checkOutput("s6NoFault", 32'(out_fault), 32'd0);
    end

    // The PC wraps from the top of the address space to zero.
    doReset();
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s7Addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s7Pc", out_pc, 32'hFFFF_FFFC);
    checkOutput("s7WrapAddr", imem_addr, 32'h0000_0000);

    // Randomized traffic: variable memory latency, ready stalls on both
    // sides, and sporadic redirects (some of them misaligned).
    doReset();
    rdataMode = 1'b1;
    readyPct  = 70;
    xferCount = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        rd;
      logic [31:0] tgt;
      memLat = $urandom_range(4, 1);
      rd     = ($urandom_range(99) < 5);
      tgt    = $urandom;
      if (!(TRAP && ($urandom_range(7) == 0))) tgt[1:0] = TRAP ? 2'b00 : tgt[1:0];
      applyStimulus(rd, tgt, ($urandom_range(99) < 70) ? 1'b1 : 1'b0);
    end
    checkOutput("liveness", 32'(xferCount >= 200), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly downstream of the branch unit: holds the architectural PC, accepts the taken-redirect target produced in execute, and drives the instruction-memory port. It issues one outstanding request at a time and squashes wrong-path responses after a redirect. Fetched instructions go to decode through a one-entry valid/ready output buffer.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- redirect  in  1  taken change of flow from execute; single-cycle pulse.
- redirect_pc  in  32  target PC (branch unit new_pc), sampled when redirect=1.
- imem_req  out  1  memory request valid.
- imem_addr  out  32  request address (word-aligned).
- imem_ready  in  1  memory accepts request when imem_req && imem_ready.
- imem_rvalid  in  1  response valid; at most one per accepted request, ≥1 cycle after acceptance.
- imem_rdata  in  32  response instruction word.
- out_valid  out  1  output buffer holds an instruction.
- out_ready  in  1  decode accepts; transfer when out_valid && out_ready.
- out_instr  out  32  fetched instruction.
- out_pc  out  32  address of out_instr.
- out_fault  out  1  misaligned-fetch fault marker (see Configuration).

## Operation
- Registers: pc, state {S_REQ, S_WAIT, S_FAULT}, kill, output buffer (out_valid/out_instr/out_pc/out_fault).
- S_REQ: imem_addr=pc; imem_req=1 iff (!out_valid || out_ready) && !redirect. On acceptance -> S_WAIT. Issue gating guarantees the buffer is empty when the response arrives; imem_rvalid is never back-pressured.
- S_WAIT: imem_req=0. On imem_rvalid: if kill=1 discard, kill<=0, -> S_REQ (pc unchanged, already redirected); else out_instr<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+4, -> S_REQ.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Redirect (any state): pc<=redirect_pc; out_valid<=0 (buffered instruction is wrong-path). In S_WAIT without imem_rvalid: kill<=1, stay S_WAIT. In S_WAIT with imem_rvalid same cycle: response discarded, kill<=0, -> S_REQ. In S_REQ: no request issued that cycle, stay S_REQ. In S_FAULT: -> S_REQ.
- Back-to-back redirects: last target wins; kill stays 1 until the single in-flight response returns.
- A transfer coinciding with redirect is discarded by both sides (decode is flushed by the same redirect).
- Output buffer: cleared on transfer unless reloaded the same cycle; holds value while out_valid && !out_ready.

## Timing
- Reset values: pc=RESET_PC, state=S_REQ, kill=0, out_valid=0, out_instr=32'h0000_0013, out_pc=RESET_PC, out_fault=0, imem_req=0 while rst=1, imem_addr=RESET_PC.
- First request in the first cycle after rst deasserts.
- Latency: imem_rvalid at cycle t -> out_valid=1 at t+1. With zero-wait memory (rvalid one cycle after acceptance) and out_ready=1: one instruction per 2 cycles.
- Redirect at cycle t -> imem_addr=redirect_pc at t+1; first request at t+1 if in S_REQ, else after the killed response returns.
- imem_req/imem_addr are combinational from registered state plus out_ready/redirect; no other comb paths.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: in S_REQ with pc[1:0]!=0 (and buffer free, no redirect), no memory request; load buffer with out_instr=32'h0000_0013, out_pc=pc, out_fault=1, out_valid=1; -> S_FAULT, idle until the next redirect.
- Undefined: redirect_pc[1:0] forced to 2'b00 when loaded into pc; out_fault tied 0; S_FAULT unreachable.

## Test plan
- Reset RESET_PC=32'h100, memory returns 32'h00A00093 one cycle after acceptance, out_ready=1 -> out_pc sequence 0x100, 0x104, 0x108, one transfer per 2 cycles.
- out_ready=0 for 5 cycles after first instruction -> out_valid held with out_pc=0x100, imem_req=0, no second request until out_ready=1.
- Redirect to 0x200 in S_WAIT, response for 0x104 arrives 3 cycles later -> response dropped, next request addr 0x200, out_pc=0x200 next.
- Redirect to 0x300 coincident with imem_rvalid -> that word dropped, out_valid=0, request at 0x300 the following cycle.
- Redirects to 0x400 then 0x500 on consecutive cycles in S_WAIT -> only 0x500 fetched.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x602 -> out_fault=1, out_pc=0x602, out_instr=0x00000013, no imem_req until redirect to 0x700; without macro, fetch at 0x600.
